// File: rtl/btb_predictor_pkg.sv
// Shared definitions for the branch target buffer: counter encodings,
// flush FSM states and entry-field width helpers.
package btb_predictor_pkg;

  // 2-bit direction counter; bit 1 set means predict taken
  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } flush_st_e;

  // Targets are word aligned, so the low two bits are never stored
  function automatic int tgt_bits(input int wpc);
    return wpc - 2;
  endfunction

  function automatic int depth_of(input int index_bits);
    return 1 << index_bits;
  endfunction

endpackage

// File: rtl/btb_predictor_sat_counter2.sv
// 2-bit saturating up/down counter, next-state only (combinational).
module sat_counter2
  import btb_predictor_pkg::*;
(
  input  logic [1:0] i_ctr,
  input  logic       i_taken,
  output logic [1:0] o_ctr
);

  // Step toward strong-taken or strong-not-taken, holding at the ends
  always_comb begin
    o_ctr = i_ctr;
    if (i_taken) begin
      if (i_ctr != CTR_ST) o_ctr = i_ctr + 2'd1;
    end else begin
      if (i_ctr != CTR_SNT) o_ctr = i_ctr - 2'd1;
    end
  end

endmodule

// File: rtl/btb_predictor.sv
// Branch target buffer with 2-bit direction counters, allocate-on-miss
// training and a sequential one-entry-per-cycle flush engine.
// Optional macro BTB_BYPASS_EN: a same-cycle update to the looked-up entry
// is forwarded to the lookup outputs; otherwise it is seen a cycle later.
module btb_predictor
  import btb_predictor_pkg::*;
#(
  parameter int WIDTH_PC   = 32,
  parameter int INDEX_BITS = 7,
  parameter int TAG_BITS   = 7
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_lookup_valid,
  input  logic [WIDTH_PC-1:0] i_lookup_pc,
  output logic                o_hit,
  output logic                o_pred_taken,
  output logic [WIDTH_PC-1:0] o_pred_pc,
  input  logic                i_upd_valid,
  input  logic [WIDTH_PC-1:0] i_upd_pc,
  input  logic                i_upd_taken,
  input  logic [WIDTH_PC-1:0] i_upd_target,
  input  logic                i_flush_req,
  output logic                o_flush_busy
);

  localparam int DEPTH = depth_of(INDEX_BITS);
  localparam int TGT_W = tgt_bits(WIDTH_PC);
  localparam int TAG_LO = INDEX_BITS + 2;
  localparam int TAG_HI = INDEX_BITS + TAG_BITS + 1;

  logic [DEPTH-1:0]    r_valid;
  logic [TAG_BITS-1:0] r_tag    [DEPTH];
  logic [1:0]          r_ctr    [DEPTH];
  logic [TGT_W-1:0]    r_target [DEPTH];

  flush_st_e             r_state;
  logic                  r_busy;
  logic [INDEX_BITS-1:0] r_fidx;

  logic [INDEX_BITS-1:0] w_lk_idx, w_up_idx;
  logic [TAG_BITS-1:0]   w_lk_tag, w_up_tag;
  logic                  w_upd_acc, w_up_hit;
  logic [1:0]            w_sat_ctr, w_init_ctr, w_new_ctr;
  logic [TGT_W-1:0]      w_new_tgt;
  logic                  w_e_valid;
  logic [TAG_BITS-1:0]   w_e_tag;
  logic [1:0]            w_e_ctr;
  logic [TGT_W-1:0]      w_e_tgt;
  logic                  w_unused;

  assign w_lk_idx = i_lookup_pc[INDEX_BITS+1:2];
  assign w_lk_tag = i_lookup_pc[TAG_HI:TAG_LO];
  assign w_up_idx = i_upd_pc[INDEX_BITS+1:2];
  assign w_up_tag = i_upd_pc[TAG_HI:TAG_LO];
  assign w_unused = ^{i_upd_pc, i_upd_target[1:0]};

  // Training only in IDLE; a same-cycle flush request wins over it
  assign w_upd_acc = i_upd_valid & (r_state == ST_IDLE) & ~i_flush_req;
  assign w_up_hit  = r_valid[w_up_idx] & (r_tag[w_up_idx] == w_up_tag);

  sat_counter2 u_ctr_train (
    .i_ctr   (r_ctr[w_up_idx]),
    .i_taken (i_upd_taken),
    .o_ctr   (w_sat_ctr)
  );

  // Allocation seed: one step from the opposite weak state lands on
  // weak-T for taken and weak-NT for not-taken
  sat_counter2 u_ctr_alloc (
    .i_ctr   (i_upd_taken ? CTR_WNT : CTR_WT),
    .i_taken (i_upd_taken),
    .o_ctr   (w_init_ctr)
  );

  assign w_new_ctr = w_up_hit ? w_sat_ctr : w_init_ctr;
  assign w_new_tgt = (w_up_hit & ~i_upd_taken) ? r_target[w_up_idx]
                                               : i_upd_target[WIDTH_PC-1:2];

  // Select the entry seen by lookup, optionally forwarding this cycle's update
  always_comb begin
    w_e_valid = r_valid[w_lk_idx];
    w_e_tag   = r_tag[w_lk_idx];
    w_e_ctr   = r_ctr[w_lk_idx];
    w_e_tgt   = r_target[w_lk_idx];
`ifdef BTB_BYPASS_EN
    if (w_upd_acc && (w_up_idx == w_lk_idx) && (w_up_tag == w_lk_tag)) begin
      w_e_valid = 1'b1;
      w_e_tag   = w_up_tag;
      w_e_ctr   = w_new_ctr;
      w_e_tgt   = w_new_tgt;
    end
`endif
  end

  assign o_hit        = i_lookup_valid & ~r_busy & w_e_valid & (w_e_tag == w_lk_tag);
  assign o_pred_taken = o_hit & w_e_ctr[1];
  assign o_pred_pc    = o_pred_taken ? {w_e_tgt, 2'b00} : i_lookup_pc + WIDTH_PC'(4);
  assign o_flush_busy = r_busy;

  // Flush sequencer: walks every index once, then returns to IDLE
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_fidx  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (i_flush_req) begin
          r_state <= ST_FLUSH;
          r_busy  <= 1'b1;
          r_fidx  <= '0;
        end
        ST_FLUSH: begin
          r_fidx <= r_fidx + 1'b1;
          if (r_fidx == INDEX_BITS'(DEPTH - 1)) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Valid bits: the only reset state in the table
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
    end else if (r_state == ST_FLUSH) begin
      r_valid[r_fidx] <= 1'b0;
    end else if (w_upd_acc) begin
      r_valid[w_up_idx] <= 1'b1;
    end
  end

  // Entry payload; meaningless until the matching valid bit is set
  always_ff @(posedge i_clk) begin
    if (w_upd_acc) begin
      r_tag[w_up_idx]    <= w_up_tag;
      r_ctr[w_up_idx]    <= w_new_ctr;
      r_target[w_up_idx] <= w_new_tgt;
    end
  end

endmodule

// File: tb/tb_btb_predictor.sv
// Randomised and directed bench for btb_predictor against a table model.
module tb_btb_predictor;

  localparam int IB = 7;
  localparam int TB = 7;
  localparam int DEPTH = 1 << IB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lookup_valid = 1'b0;
  logic [31:0] lookup_pc = '0;
  logic        hit, pred_taken, flush_busy;
  logic [31:0] pred_pc;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        flush_req = 1'b0;

  btb_predictor #(.WIDTH_PC(32), .INDEX_BITS(IB), .TAG_BITS(TB)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_lookup_valid(lookup_valid), .i_lookup_pc(lookup_pc),
    .o_hit(hit), .o_pred_taken(pred_taken), .o_pred_pc(pred_pc),
    .i_upd_valid(upd_valid), .i_upd_pc(upd_pc), .i_upd_taken(upd_taken),
    .i_upd_target(upd_target), .i_flush_req(flush_req), .o_flush_busy(flush_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    int          tag;
    int          ctr;
    logic [31:0] tgt;
  } ent_t;

  ent_t m[DEPTH];
  int   flush_left;
  int   n_chk = 0;
  int   n_err = 0;
  logic o_hit_s, o_pt_s, o_busy_s;
  logic [31:0] o_ppc_s;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc >> 2) % DEPTH);
  endfunction

  function automatic int m_tag(input logic [31:0] pc);
    return int'((pc >> (2 + IB)) % (1 << TB));
  endfunction

  // Resolved-branch effect on one entry, from the training rules
  function automatic ent_t upd_ent(input ent_t e, input int tg, input bit tk, input logic [31:0] tgt);
    ent_t n = e;
    if (e.v && e.tag == tg) begin
      if (tk) n.ctr = (e.ctr == 3) ? 3 : e.ctr + 1;
      else    n.ctr = (e.ctr == 0) ? 0 : e.ctr - 1;
      if (tk) n.tgt = tgt & ~32'h3;
    end else begin
      n.v = 1'b1; n.tag = tg; n.ctr = tk ? 2 : 1; n.tgt = tgt & ~32'h3;
    end
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m[i].v = 1'b0;
    flush_left = 0;
  endtask

  // One clock: drive, check combinational outputs at negedge, advance model at posedge
  task automatic step(input bit lv, input logic [31:0] lpc, input bit uv, input logic [31:0] upc,
                      input bit ut, input logic [31:0] utgt, input bit fr);
    ent_t e;
    bit   busy, ehit, ept, accepted;
    logic [31:0] eppc;
    lookup_valid = lv; lookup_pc = lpc; upd_valid = uv; upd_pc = upc;
    upd_taken = ut; upd_target = utgt; flush_req = fr;
    @(negedge clk);
    busy = flush_left > 0;
    accepted = uv && !busy && !fr;
    e = m[m_idx(lpc)];
`ifdef BTB_BYPASS_EN
    if (accepted && m_idx(upc) == m_idx(lpc) && m_tag(upc) == m_tag(lpc))
      e = upd_ent(m[m_idx(upc)], m_tag(upc), ut, utgt);
`endif
    ehit = lv && !busy && e.v && e.tag == m_tag(lpc);
    ept  = ehit && e.ctr >= 2;
    eppc = ept ? e.tgt : lpc + 32'd4;
    o_hit_s = hit; o_pt_s = pred_taken; o_ppc_s = pred_pc; o_busy_s = flush_busy;
    chk("hit", hit, 32'(ehit));
    chk("pred_taken", pred_taken, 32'(ept));
    chk("pred_pc", pred_pc, eppc);
    chk("flush_busy", flush_busy, 32'(busy));
    @(posedge clk);
    if (busy) flush_left--;
    else if (fr) begin
      for (int i = 0; i < DEPTH; i++) m[i].v = 1'b0;
      flush_left = DEPTH;
    end else if (uv) m[m_idx(upc)] = upd_ent(m[m_idx(upc)], m_tag(upc), ut, utgt);
    #1;
  endtask

  task automatic look(input logic [31:0] pc);
    step(1'b1, pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic train(input logic [31:0] pc, input bit tk, input logic [31:0] tgt);
    step(1'b0, 32'h0, 1'b1, pc, tk, tgt, 1'b0);
  endtask

  function automatic logic [31:0] rpc();
    logic [31:0] p = $urandom;
    p[IB+1:2]     = ($urandom_range(0, 9) == 0) ? IB'(DEPTH - 1) : IB'($urandom_range(0, 3));
    p[IB+TB+1:IB+2] = TB'($urandom_range(0, 2));
    return p;
  endfunction

  initial begin
    int bc;
    model_reset();
    lookup_valid = 1'b1; lookup_pc = 32'h1234;
    @(negedge clk);
    chk("rst_hit", hit, 32'd0);
    chk("rst_pt", pred_taken, 32'd0);
    chk("rst_ppc", pred_pc, 32'h1238);
    chk("rst_busy", flush_busy, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    look(32'h1234);
    chk("post_rst_hit", o_hit_s, 32'd0);
    step(1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("lv0_wrap", o_ppc_s, 32'h0);

    // allocate taken, then two not-taken
    train(32'h100, 1'b1, 32'h200);
    look(32'h100);
    chk("alloc_hit", o_hit_s, 32'd1);
    chk("alloc_pt", o_pt_s, 32'd1);
    chk("alloc_ppc", o_ppc_s, 32'h200);
    train(32'h100, 1'b0, 32'h0);
    train(32'h100, 1'b0, 32'h0);
    look(32'h100);
    chk("snt_pt", o_pt_s, 32'd0);
    chk("snt_ppc", o_ppc_s, 32'h104);

    // saturate high, one step back still predicts taken
    repeat (4) train(32'h100, 1'b1, 32'h200);
    train(32'h100, 1'b0, 32'h0);
    look(32'h100);
    chk("sat_pt", o_pt_s, 32'd1);
    chk("sat_ppc", o_ppc_s, 32'h200);

    // aliasing on the same index with a different tag
    train(32'h8100, 1'b0, 32'h300);
    look(32'h100);
    chk("alias_old_hit", o_hit_s, 32'd0);
    look(32'h8100);
    chk("alias_new_hit", o_hit_s, 32'd1);
    chk("alias_new_pt", o_pt_s, 32'd0);

    // same-cycle update and lookup on a weak-taken entry
    train(32'h100, 1'b1, 32'h200);
    step(1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
`ifdef BTB_BYPASS_EN
    chk("same_cyc_pt", o_pt_s, 32'd0);
`else
    chk("same_cyc_pt", o_pt_s, 32'd1);
`endif
    look(32'h100);
    chk("next_cyc_pt", o_pt_s, 32'd0);

    // flush: length, dropped update, table empty afterwards
    train(32'h100, 1'b1, 32'h200);
    train(32'h204, 1'b1, 32'h400);
    train(32'h1FC, 1'b1, 32'h800);
    step(1'b1, 32'h204, 1'b1, 32'h300, 1'b1, 32'h40, 1'b1);
    bc = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      step(1'b1, 32'h100, i == 50, 32'h100, 1'b1, 32'h200, i == 60);
      if (o_busy_s) bc++;
    end
    chk("flush_len", 32'(bc), 32'(DEPTH));
    look(32'h100);  chk("fl_hit0", o_hit_s, 32'd0);
    look(32'h204);  chk("fl_hit1", o_hit_s, 32'd0);
    look(32'h1FC);  chk("fl_hit2", o_hit_s, 32'd0);
    look(32'h300);  chk("fl_hit3", o_hit_s, 32'd0);

    // asynchronous reset in the middle of a flush
    train(32'h100, 1'b1, 32'h200);
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    repeat (10) look(32'h100);
    chk("midfl_busy_before", flush_busy, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midfl_busy_rst", flush_busy, 32'd0);
    chk("midfl_hit_rst", hit, 32'd0);
    model_reset();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    look(32'h100);
    chk("post_midfl_hit", o_hit_s, 32'd0);

    // randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 4) != 0, rpc(), $urandom_range(0, 1) == 1, rpc(),
           $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 149) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
